spiral_wipe_gen: RTL and testbench
==================================

Name: spiral_wipe_gen

Overview:
Parametrised spiral screen-wipe pixel generator feeding the VGA plotter. On `start` it walks every pixel of a WIDTH x HEIGHT frame exactly once, in a rectangular spiral from (0,0) toward the centre. It drives coordinates plus colour with a valid/ready plot handshake. Adds over the previous transition generator:
- generic frame size
- clockwise/counter-clockwise mode
- backpressure
- abort
- exact pixel-count termination
- restartability without reset

Parameters:
WIDTH, 320, frame width in pixels (>=1)
HEIGHT, 240, frame height in pixels (>=1)
XW, 9, x coordinate width; must hold WIDTH-1
YW, 9, y coordinate width; must hold HEIGHT-1
COLOR_W, 3, colour width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin wipe; sampled in IDLE or DONE only
ccw  in  1  direction mode, latched at start: 0 = clockwise, 1 = counter-clockwise
colour_in  in  COLOR_W  wipe colour, latched at start
abort  in  1  cancel the current wipe
plot_ready  in  1  plotter accepts the current pixel
plot  out  1  x_out/y_out/colour_out valid
x_out  out  XW  pixel x
y_out  out  YW  pixel y
colour_out  out  COLOR_W  pixel colour
busy  out  1  high in RUN
done  out  1  high in DONE; held until the next start or reset

Behaviour:
- Reset (async, reset=0):
  - state = IDLE.
  - plot, busy, done, x_out, y_out, colour_out = 0.
  - Bounds return to full frame; pixel counter = 0.
- States: IDLE, RUN, DONE.
- start in IDLE or DONE:
  - Latch ccw and colour_in.
  - xmin=0, ymin=0, xmax=WIDTH-1, ymax=HEIGHT-1, x=y=0, count=0.
  - First direction: RIGHT if ccw=0, DOWN if ccw=1.
  - Enter RUN; done drops the same edge.
  - Next cycle: plot=1 with (0,0). Latency 1 clock from start to first valid pixel.
- RUN: plot=1 continuously.
  - A pixel is transferred on a clock edge where plot && plot_ready.
  - While plot_ready=0, x_out/y_out/colour_out hold stable.
  - One pixel per clock at full throughput.
- Per transferred pixel: count++. If count reaches WIDTH*HEIGHT-1 (last pixel accepted), go to DONE: plot=0, busy=0, done=1.
- Otherwise step. At a leg end, shrink the completed boundary, turn, and step one pixel in the new direction.
- Clockwise cycle:
  - RIGHT until x==xmax, then ymin++ and turn DOWN.
  - DOWN until y==ymax, then xmax-- and turn LEFT.
  - LEFT until x==xmin, then ymax-- and turn UP.
  - UP until y==ymin, then xmin++ and turn RIGHT.
- Counter-clockwise cycle:
  - DOWN until y==ymax, then xmin++ and turn RIGHT.
  - RIGHT until x==xmax, then ymax-- and turn UP.
  - UP until y==ymin, then xmax-- and turn LEFT.
  - LEFT until x==xmin, then ymin++ and turn DOWN.
- Coverage: every coordinate emitted exactly once; never outside [0,WIDTH-1] x [0,HEIGHT-1].
- Pixel counter width: $clog2(WIDTH*HEIGHT+1); no wrap.
- Degenerate frames:
  - WIDTH=1 or HEIGHT=1 produce a single straight leg.
  - WIDTH=HEIGHT=1 emits (0,0) then DONE.
- abort in RUN: next edge returns to IDLE with plot=0 and busy=0; done stays 0. abort has priority over a simultaneous transfer.
- start while in RUN is ignored. start and abort together in IDLE/DONE: start wins.

Optional Feature:
Macro SPIRAL_RING_STRIPE_EN.
- Defined: a ring counter increments each time a leg-completion shrinks xmin (clockwise) or ymin (counter-clockwise).
  - colour_out = latched colour on even rings, bitwise inverse on odd rings.
  - Produces concentric stripes.
- Undefined: colour_out = latched colour for every pixel; no ring counter logic.

Test Plan:
- WIDTH=4, HEIGHT=3, ccw=0, plot_ready=1, start pulse:
  - plot rises 1 cycle after start.
  - Sequence (0,0)(1,0)(2,0)(3,0)(3,1)(3,2)(2,2)(1,2)(0,2)(0,1)(1,1)(2,1).
  - done=1 the cycle after the 12th transfer.
- Same frame, ccw=1:
  - Sequence (0,0)(0,1)(0,2)(1,2)(2,2)(3,2)(3,1)(3,0)(2,0)(1,0)(1,1)(2,1).
  - Then done.
- Default 320x240 with random plot_ready:
  - Coordinates hold while plot_ready=0.
  - Exactly 76800 transfers, no duplicates, all in range.
  - busy drops with done.
- abort after 5 transfers: IDLE next edge, plot=0, done=0. A new start then restarts at (0,0).
- reset asserted mid-wipe: all outputs 0 immediately (async). After reset release plus start, a full correct sequence follows.
- With SPIRAL_RING_STRIPE_EN, 4x3, ccw=0, colour_in=3'b101:
  - First 10 pixels colour 101.
  - Last two pixels (1,1),(2,1) colour 010.

Source files
------------

// File: rtl/spiral_wipe_gen.sv
// ---------------------------------------------------------------------------
// spiral_wipe_gen
//
// Walks every pixel of a WIDTH x HEIGHT frame exactly once, in a rectangular
// spiral from (0,0) toward the centre, and presents each pixel to a plotter
// over a valid/ready handshake (plot / plot_ready).
//
// Optional build macro: SPIRAL_RING_STRIPE_EN
//   defined   : colour alternates between the latched colour and its bitwise
//               inverse on each successive ring, giving concentric stripes.
//   undefined : every pixel carries the latched colour.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   begin a wipe (honoured in IDLE or DONE only)
//   ccw         in   direction, latched at start: 0 clockwise, 1 counter-cw
//   colour_in   in   wipe colour, latched at start
//   abort       in   cancel the running wipe (wins over a same-cycle transfer)
//   plot_ready  in   plotter accepts the presented pixel
//   plot        out  x_out/y_out/colour_out valid
//   x_out       out  pixel x
//   y_out       out  pixel y
//   colour_out  out  pixel colour
//   busy        out  high while the wipe runs
//   done        out  high after the last pixel, until next start or reset
// ---------------------------------------------------------------------------
module spiral_wipe_gen #(
    parameter int unsigned WIDTH   = 320,
    parameter int unsigned HEIGHT  = 240,
    parameter int unsigned XW      = 9,
    parameter int unsigned YW      = 9,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               ccw,
    input  logic [COLOR_W-1:0] colour_in,
    input  logic               abort,
    input  logic               plot_ready,
    output logic               plot,
    output logic [XW-1:0]      x_out,
    output logic [YW-1:0]      y_out,
    output logic [COLOR_W-1:0] colour_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned CNTW = $clog2(NPIX + 1);

    localparam logic [XW-1:0]   X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0]   Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NPIX - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {DirRight, DirDown, DirLeft, DirUp} dir_e;

    state_e r_state;
    state_e w_state_nxt;

    dir_e               r_dir;
    logic               r_ccw;
    logic [COLOR_W-1:0] r_colour;
    logic [XW-1:0]      r_x, r_xmin, r_xmax;
    logic [YW-1:0]      r_y, r_ymin, r_ymax;
    logic [CNTW-1:0]    r_count;

    dir_e               w_dir_nxt;
    logic [XW-1:0]      w_x_nxt, w_xmin_nxt, w_xmax_nxt;
    logic [YW-1:0]      w_y_nxt, w_ymin_nxt, w_ymax_nxt;

    logic w_load;
    logic w_accept;
    logic w_last;
    logic w_step;

    assign w_load   = (r_state != StRun) && start;
    // abort takes priority: a pixel offered in an aborting cycle is not consumed
    assign w_accept = (r_state == StRun) && plot_ready && !abort;
    assign w_last   = (r_count == CNT_LAST);
    assign w_step   = w_accept && !w_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    w_state_nxt = StIdle;
                end else if (plot_ready && w_last) begin
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        plot = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            StRun:   begin plot = 1'b1; busy = 1'b1; end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- spiral stepping ----------------
    // At a leg end the completed edge is retired and the walker moves one
    // pixel in the new direction, which always lands inside the shrunken box
    // because the count check stops us before the box can become empty.
    always_comb begin
        w_dir_nxt  = r_dir;
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_xmin_nxt = r_xmin;
        w_xmax_nxt = r_xmax;
        w_ymin_nxt = r_ymin;
        w_ymax_nxt = r_ymax;
        unique case (r_dir)
            DirRight: begin
                if (r_x == r_xmax) begin
                    if (!r_ccw) begin
                        w_ymin_nxt = r_ymin + YW'(1);
                        w_dir_nxt  = DirDown;
                        w_y_nxt    = r_y + YW'(1);
                    end else begin
                        w_ymax_nxt = r_ymax - YW'(1);
                        w_dir_nxt  = DirUp;
                        w_y_nxt    = r_y - YW'(1);
                    end
                end else begin
                    w_x_nxt = r_x + XW'(1);
                end
            end
            DirDown: begin
                if (r_y == r_ymax) begin
                    if (!r_ccw) begin
                        w_xmax_nxt = r_xmax - XW'(1);
                        w_dir_nxt  = DirLeft;
                        w_x_nxt    = r_x - XW'(1);
                    end else begin
                        w_xmin_nxt = r_xmin + XW'(1);
                        w_dir_nxt  = DirRight;
                        w_x_nxt    = r_x + XW'(1);
                    end
                end else begin
                    w_y_nxt = r_y + YW'(1);
                end
            end
            DirLeft: begin
                if (r_x == r_xmin) begin
                    if (!r_ccw) begin
                        w_ymax_nxt = r_ymax - YW'(1);
                        w_dir_nxt  = DirUp;
                        w_y_nxt    = r_y - YW'(1);
                    end else begin
                        w_ymin_nxt = r_ymin + YW'(1);
                        w_dir_nxt  = DirDown;
                        w_y_nxt    = r_y + YW'(1);
                    end
                end else begin
                    w_x_nxt = r_x - XW'(1);
                end
            end
            DirUp: begin
                if (r_y == r_ymin) begin
                    if (!r_ccw) begin
                        w_xmin_nxt = r_xmin + XW'(1);
                        w_dir_nxt  = DirRight;
                        w_x_nxt    = r_x + XW'(1);
                    end else begin
                        w_xmax_nxt = r_xmax - XW'(1);
                        w_dir_nxt  = DirLeft;
                        w_x_nxt    = r_x - XW'(1);
                    end
                end else begin
                    w_y_nxt = r_y - YW'(1);
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dir    <= DirRight;
            r_ccw    <= 1'b0;
            r_colour <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_xmin   <= '0;
            r_ymin   <= '0;
            r_xmax   <= X_LAST;
            r_ymax   <= Y_LAST;
            r_count  <= '0;
        end else if (w_load) begin
            r_dir    <= ccw ? DirDown : DirRight;
            r_ccw    <= ccw;
            r_colour <= colour_in;
            r_x      <= '0;
            r_y      <= '0;
            r_xmin   <= '0;
            r_ymin   <= '0;
            r_xmax   <= X_LAST;
            r_ymax   <= Y_LAST;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + CNTW'(1);
            end
            if (w_step) begin
                r_dir  <= w_dir_nxt;
                r_x    <= w_x_nxt;
                r_y    <= w_y_nxt;
                r_xmin <= w_xmin_nxt;
                r_xmax <= w_xmax_nxt;
                r_ymin <= w_ymin_nxt;
                r_ymax <= w_ymax_nxt;
            end
        end
    end

    assign x_out = r_x;
    assign y_out = r_y;

`ifdef SPIRAL_RING_STRIPE_EN
    // Only the ring parity matters for the stripe, so a one-bit counter.
    // A new ring begins when the leading edge of the cycle (xmin for cw,
    // ymin for ccw) is retired.
    logic r_ring_odd;
    logic w_ring_inc;

    assign w_ring_inc = w_step &&
                        ((!r_ccw && (r_dir == DirUp)   && (r_y == r_ymin)) ||
                         ( r_ccw && (r_dir == DirLeft) && (r_x == r_xmin)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ring_odd <= 1'b0;
        end else if (w_load) begin
            r_ring_odd <= 1'b0;
        end else if (w_ring_inc) begin
            r_ring_odd <= ~r_ring_odd;
        end
    end

    assign colour_out = r_ring_odd ? ~r_colour : r_colour;
`else
    assign colour_out = r_colour;
`endif

endmodule

// File: tb/tb_spiral_wipe_gen.sv
// ---------------------------------------------------------------------------
// tb_spiral_wipe_gen
//
// Scoreboard bench for spiral_wipe_gen on a 4x3 frame. Stimulus tasks push
// hand-computed pixel sequences into a queue; a monitor on the falling edge
// pops and compares on every offered transfer and checks that an unaccepted
// pixel is held stable.
// ---------------------------------------------------------------------------
module tb_spiral_wipe_gen;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int XW  = 3;
    localparam int YW  = 2;
    localparam int CW  = 3;
    localparam int N   = W * H;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          ccw;
    logic [CW-1:0] colour_in;
    logic          abort;
    logic          plot_ready;
    logic          plot;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [CW-1:0] colour_out;
    logic          busy;
    logic          done;

    spiral_wipe_gen #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .XW      (XW),
        .YW      (YW),
        .COLOR_W (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ccw        (ccw),
        .colour_in  (colour_in),
        .abort      (abort),
        .plot_ready (plot_ready),
        .plot       (plot),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_xfer   = 0;

    // Hand-derived spiral orders for the 4x3 frame.
    int cw_x[N]  = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 1, 2};
    int cw_y[N]  = '{0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 1, 1};
    int ccw_x[N] = '{0, 0, 0, 1, 2, 3, 3, 3, 2, 1, 1, 2};
    int ccw_y[N] = '{0, 1, 2, 2, 2, 2, 1, 0, 0, 0, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic held_v = 1'b0;
    pix_t held;

    always @(negedge clock) begin
        pix_t e;
        pix_t cur;
        cur = {x_out, y_out, colour_out};
        if (held_v && plot) begin
            check("hold_stable", 32'(cur), 32'(held));
        end
        held_v = 1'b0;
        if (plot && reset && !abort) begin
            if (plot_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", x_out, y_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'(cur), 32'(e));
                    n_xfer++;
                end
            end else begin
                held_v = 1'b1;
                held   = cur;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_seq(input logic dir, input logic [CW-1:0] col);
        pix_t p;
        n_xfer = 0;
        for (int i = 0; i < N; i++) begin
            p.x = XW'(dir ? ccw_x[i] : cw_x[i]);
            p.y = YW'(dir ? ccw_y[i] : cw_y[i]);
            p.c = col;
`ifdef SPIRAL_RING_STRIPE_EN
            // the centre row (1,1),(2,1) is the second ring in both directions
            if (i >= 10) p.c = ~col;
`endif
            exp_q.push_back(p);
        end
    endtask

    task automatic do_start(input logic dir, input logic [CW-1:0] col, input logic ab);
        @(posedge clock);
        #1;
        start     = 1'b1;
        abort     = ab;
        ccw       = dir;
        colour_in = col;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("first_plot", 32'(plot), 32'd1);
        check("busy_in_run", 32'(busy), 32'd1);
        check("done_dropped", 32'(done), 32'd0);
    endtask

    // rnd: randomise plot_ready and poke start mid-run; exp_cyc > 0 checks latency
    task automatic wait_done(input bit rnd, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
            if (rnd) begin
                plot_ready = 1'($urandom_range(0, 1));
                start      = (cyc == 3);
            end
        end
        start      = 1'b0;
        plot_ready = 1'b1;
        check("done_reached", 32'(done), 32'd1);
        if (exp_cyc > 0) check("done_latency", 32'(cyc), 32'(exp_cyc));
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("plot_low_at_done", 32'(plot), 32'd0);
        check("transfers", 32'(n_xfer), 32'(N));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
        check("done_held", 32'(done), 32'd1);
    endtask

    task automatic wait_xfers(input int n);
        int cyc;
        cyc = 0;
        while (n_xfer < n && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("xfer_count_reached", 32'(n_xfer), 32'(n));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_plot"}, 32'(plot), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_x"}, 32'(x_out), 32'd0);
        check({tag, "_y"}, 32'(y_out), 32'd0);
        check({tag, "_colour"}, 32'(colour_out), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        ccw        = 1'b0;
        colour_in  = '0;
        plot_ready = 1'b1;

        #12;
        check_zero_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        // clockwise, full throughput
        push_seq(1'b0, 3'b101);
        do_start(1'b0, 3'b101, 1'b0);
        wait_done(1'b0, N);

        // counter-clockwise, restart straight from DONE
        push_seq(1'b1, 3'b110);
        do_start(1'b1, 3'b110, 1'b0);
        wait_done(1'b0, N);

        // random backpressure, start pulses during RUN must be ignored
        push_seq(1'b0, 3'b011);
        do_start(1'b0, 3'b011, 1'b0);
        wait_done(1'b1, 0);

        push_seq(1'b1, 3'b001);
        do_start(1'b1, 3'b001, 1'b0);
        wait_done(1'b1, 0);

        // abort after five transfers, offered pixel must not be consumed
        push_seq(1'b0, 3'b101);
        do_start(1'b0, 3'b101, 1'b0);
        wait_xfers(5);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_remaining", 32'(exp_q.size()), 32'(N - 5));
        exp_q.delete();

        // start together with abort from IDLE: start wins
        push_seq(1'b1, 3'b010);
        do_start(1'b1, 3'b010, 1'b1);
        wait_done(1'b0, N);

        // asynchronous reset mid-wipe
        push_seq(1'b0, 3'b111);
        do_start(1'b0, 3'b111, 1'b0);
        wait_xfers(3);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;

        push_seq(1'b0, 3'b100);
        do_start(1'b0, 3'b100, 1'b0);
        wait_done(1'b0, N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
